// File: rtl/fetch_queue.sv
// fetch_queue: instruction prefetch queue with a single-outstanding-request
// memory fetch engine and redirect (jump/branch) handling.
//
// Ports:
//   clk          rising-edge clock
//   rst          synchronous active-high reset
//   imem_req     instruction-memory request (registered)
//   imem_addr    request word address (registered)
//   imem_ack     one-cycle response strobe from memory
//   imem_rdata   instruction word, valid with imem_ack
//   alt_pc_ctrl  redirect strobe; flushes the queue and reloads the fetch pc
//   alt_pc       redirect target
//   stall        consumer not accepting the head entry
//   hlt          freezes consumption and new requests
//   instr        head instruction (zero when valid=0)
//   pc_plus_1    head entry fetch address + 1 (zero when valid=0)
//   valid        head entry present
//
// Optional feature: define FETCH_QUEUE_BYPASS_EN to forward a response
// straight to the outputs in its arrival cycle when the queue is empty.
module fetch_queue #(
    parameter int unsigned DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [15:0] imem_addr,
    input  logic        imem_ack,
    input  logic [15:0] imem_rdata,
    input  logic        alt_pc_ctrl,
    input  logic [15:0] alt_pc,
    input  logic        stall,
    input  logic        hlt,
    output logic [15:0] instr,
    output logic [15:0] pc_plus_1,
    output logic        valid
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = AW + 1;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_WAIT    = 2'd1,
        S_DISCARD = 2'd2
    } state_t;

    state_t         r_state;
    state_t         w_state_nxt;
    logic [15:0]    r_fpc;
    logic [15:0]    w_fpc_nxt;
    logic           r_req;
    logic           w_req_nxt;
    logic [15:0]    r_addr;
    logic [15:0]    w_addr_nxt;

    logic [CW-1:0]  r_count;
    logic [AW-1:0]  r_rd_ptr;
    logic [AW-1:0]  r_wr_ptr;
    logic [15:0]    r_q_instr [DEPTH];
    logic [15:0]    r_q_pc1   [DEPTH];

    logic           w_q_valid;
    logic           w_pop;
    logic           w_ack_ok;
    logic           w_bypass;
    logic           w_push;
    logic [CW-1:0]  w_count_after_pop;
    logic           w_can_issue;
    logic [15:0]    w_fpc_inc;

    assign w_fpc_inc         = r_fpc + 16'd1;
    assign w_q_valid         = (r_count != '0);
    // Queue pop: only real queue entries are consumed here.
    assign w_pop             = w_q_valid & ~stall & ~hlt & ~alt_pc_ctrl;
    assign w_ack_ok          = (r_state == S_WAIT) & imem_ack & ~alt_pc_ctrl;
    assign w_count_after_pop = r_count - CW'(w_pop);
    // Issue only if the response is guaranteed a free slot.
    assign w_can_issue       = ~hlt & ~alt_pc_ctrl & (w_count_after_pop < CW'(DEPTH));

`ifdef FETCH_QUEUE_BYPASS_EN
    // Response is consumed in its arrival cycle, so it never enters the queue.
    assign w_bypass = w_ack_ok & ~w_q_valid & ~stall & ~hlt;
`else
    assign w_bypass = 1'b0;
`endif

    assign w_push = w_ack_ok & ~w_bypass;

    // Fetch FSM state and registered memory interface.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_fpc   <= 16'h0000;
            r_req   <= 1'b0;
            r_addr  <= 16'h0000;
        end else begin
            r_state <= w_state_nxt;
            r_fpc   <= w_fpc_nxt;
            r_req   <= w_req_nxt;
            r_addr  <= w_addr_nxt;
        end
    end

    // Fetch FSM next-state logic.
    always_comb begin
        w_state_nxt = r_state;
        w_fpc_nxt   = r_fpc;
        w_req_nxt   = r_req;
        w_addr_nxt  = r_addr;
        case (r_state)
            S_IDLE: begin
                if (alt_pc_ctrl) begin
                    w_fpc_nxt = alt_pc;
                end else if (w_can_issue) begin
                    w_state_nxt = S_WAIT;
                    w_req_nxt   = 1'b1;
                    w_addr_nxt  = r_fpc;
                end
            end
            S_WAIT: begin
                if (alt_pc_ctrl) begin
                    w_fpc_nxt = alt_pc;
                    if (imem_ack) begin
                        w_state_nxt = S_IDLE;
                        w_req_nxt   = 1'b0;
                    end else begin
                        // Request stays held until memory answers; answer is dropped.
                        w_state_nxt = S_DISCARD;
                    end
                end else if (imem_ack) begin
                    w_state_nxt = S_IDLE;
                    w_req_nxt   = 1'b0;
                    w_fpc_nxt   = w_fpc_inc;
                end
            end
            S_DISCARD: begin
                if (alt_pc_ctrl) begin
                    w_fpc_nxt = alt_pc;
                end
                // The awaited response is dropped even if a redirect lands with it;
                // waiting for a second ack would deadlock.
                if (imem_ack) begin
                    w_state_nxt = S_IDLE;
                    w_req_nxt   = 1'b0;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_req_nxt   = 1'b0;
            end
        endcase
    end

    // Queue pointers and occupancy; a redirect flushes everything.
    always_ff @(posedge clk) begin
        if (rst || alt_pc_ctrl) begin
            r_count  <= '0;
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            r_count <= r_count + CW'(w_push) - CW'(w_pop);
        end
    end

    // Queue storage; contents are don't-care while not counted.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_q_instr[r_wr_ptr] <= imem_rdata;
            r_q_pc1[r_wr_ptr]   <= w_fpc_inc;
        end
    end

    // Head presentation, zeroed when nothing is valid.
    always_comb begin
        valid     = w_q_valid;
        instr     = 16'h0000;
        pc_plus_1 = 16'h0000;
        if (w_bypass) begin
            valid     = 1'b1;
            instr     = imem_rdata;
            pc_plus_1 = w_fpc_inc;
        end else if (w_q_valid) begin
            instr     = r_q_instr[r_rd_ptr];
            pc_plus_1 = r_q_pc1[r_rd_ptr];
        end
    end

    assign imem_req  = r_req;
    assign imem_addr = r_addr;

endmodule

// File: tb/tb_fetch_queue.sv
// Directed testbench for fetch_queue with a variable-latency memory responder.
module tb_fetch_queue;

    logic        clk;
    logic        rst;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_ack;
    logic [15:0] imem_rdata;
    logic        alt_pc_ctrl;
    logic [15:0] alt_pc;
    logic        stall;
    logic        hlt;
    logic [15:0] instr;
    logic [15:0] pc_plus_1;
    logic        valid;

    int n_checks;
    int n_errors;
    int lat;
    int stale_cnt;

    fetch_queue #(.DEPTH(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .alt_pc_ctrl (alt_pc_ctrl),
        .alt_pc      (alt_pc),
        .stall       (stall),
        .hlt         (hlt),
        .instr       (instr),
        .pc_plus_1   (pc_plus_1),
        .valid       (valid)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [15:0] mem_word(input logic [15:0] a);
        return a ^ 16'hC3A5;
    endfunction

    task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Memory: acks 'lat' cycles after the request first appears; can inject one stale ack.
    initial begin
        int wait_cnt;
        int stale_done;
        logic acked;
        wait_cnt   = 0;
        stale_done = 0;
        acked      = 1'b0;
        imem_ack   = 1'b0;
        imem_rdata = 16'h0000;
        forever begin
            @(negedge clk);
            imem_ack   = 1'b0;
            imem_rdata = 16'h0000;
            if (stale_cnt != stale_done) begin
                imem_ack   = 1'b1;
                imem_rdata = 16'hDEAD;
                stale_done++;
            end else if (imem_req && !acked) begin
                wait_cnt++;
                if (wait_cnt > lat) begin
                    imem_ack   = 1'b1;
                    imem_rdata = mem_word(imem_addr);
                    acked      = 1'b1;
                end
            end
            if (!imem_req) begin
                acked    = 1'b0;
                wait_cnt = 0;
            end
        end
    end

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
    endtask

    // Consumes n entries (stall=0), checking order from pc0 and request addresses from addr0.
    task automatic collect(input int n, input logic [15:0] pc0, input logic [15:0] addr0);
        logic [15:0] pc;
        logic [15:0] ea;
        logic        prev_req;
        int          k;
        int          cyc;
        pc       = pc0;
        ea       = addr0;
        prev_req = imem_req;
        k        = 0;
        cyc      = 0;
        while (k < n && cyc < 300) begin
            if (imem_req && !prev_req) begin
                check_eq("req_addr", imem_addr, ea);
                ea = ea + 16'd1;
            end
            prev_req = imem_req;
            if (valid) begin
                check_eq("instr", instr, mem_word(pc));
                check_eq("pc_plus_1", pc_plus_1, 16'(pc + 16'd1));
                pc = pc + 16'd1;
                k++;
            end
            tick();
            cyc++;
        end
        if (k < n) check_eq("collect_timeout", 16'(k), 16'(n));
    endtask

    task automatic wait_req_addr(input logic [15:0] a);
        int cyc;
        cyc = 0;
        while (!(imem_req && imem_addr == a) && cyc < 300) begin
            tick();
            cyc++;
        end
        if (cyc >= 300) check_eq("wait_req_timeout", 16'(0), 16'(1));
    endtask

    task automatic wait_req_any();
        int cyc;
        cyc = 0;
        while (!imem_req && cyc < 300) begin
            tick();
            cyc++;
        end
        if (cyc >= 300) check_eq("wait_any_timeout", 16'(0), 16'(1));
    endtask

    // Returns just after the negedge on which the responder raised imem_ack.
    task automatic wait_ack();
        int cyc;
        cyc = 0;
        @(negedge clk);
        #1;
        while (!imem_ack && cyc < 300) begin
            @(negedge clk);
            #1;
            cyc++;
        end
        if (cyc >= 300) check_eq("wait_ack_timeout", 16'(0), 16'(1));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] a;
        int rises;
        logic prev;
        n_checks    = 0;
        n_errors    = 0;
        lat         = 1;
        stale_cnt   = 0;
        rst         = 1'b1;
        stall       = 1'b0;
        hlt         = 1'b0;
        alt_pc_ctrl = 1'b0;
        alt_pc      = 16'h0000;
        repeat (3) tick();

        // Reset state
        check_eq("rst_req", 16'(imem_req), 16'(0));
        check_eq("rst_addr", imem_addr, 16'h0000);
        check_eq("rst_valid", 16'(valid), 16'(0));
        check_eq("rst_instr", instr, 16'h0000);
        check_eq("rst_pc1", pc_plus_1, 16'h0000);
        rst = 1'b0;

        // In-order streaming from address 0, latency 1
        collect(5, 16'h0000, 16'h0000);

        // Stall held: exactly DEPTH requests, then release
        stall = 1'b1;
        do_reset();
        rises = 0;
        prev  = imem_req;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (imem_req && !prev) rises++;
            prev = imem_req;
        end
        check_eq("full_rises", 16'(rises), 16'(4));
        check_eq("full_req", 16'(imem_req), 16'(0));
        check_eq("full_valid", 16'(valid), 16'(1));
        check_eq("full_head_pc1", pc_plus_1, 16'h0001);
        check_eq("full_head_instr", instr, mem_word(16'h0000));
        stall = 1'b0;
        collect(5, 16'h0000, 16'h0004);

        // Redirect while waiting on address 5
        stall = 1'b1;
        do_reset();
        repeat (20) tick();
        stall = 1'b0;
        tick();
        tick();
        stall = 1'b1;
        lat   = 4;
        wait_req_addr(16'h0005);
        check_eq("pre_redir_valid", 16'(valid), 16'(1));
        check_eq("pre_redir_pc1", pc_plus_1, 16'h0003);
        alt_pc_ctrl = 1'b1;
        alt_pc      = 16'h0040;
        tick();
        alt_pc_ctrl = 1'b0;
        check_eq("redir_valid", 16'(valid), 16'(0));
        check_eq("redir_instr", instr, 16'h0000);
        check_eq("redir_pc1", pc_plus_1, 16'h0000);
        stall = 1'b0;
        collect(2, 16'h0040, 16'h0040);

        // Redirect coincident with ack
        lat = 2;
        wait_ack();
        alt_pc_ctrl = 1'b1;
        alt_pc      = 16'h1000;
        tick();
        alt_pc_ctrl = 1'b0;
        check_eq("redir_ack_req", 16'(imem_req), 16'(0));
        check_eq("redir_ack_valid", 16'(valid), 16'(0));
        collect(2, 16'h1000, 16'h1000);

        // Address wrap at 16'hFFFF
        alt_pc_ctrl = 1'b1;
        alt_pc      = 16'hFFFF;
        tick();
        alt_pc_ctrl = 1'b0;
        collect(2, 16'hFFFF, 16'hFFFF);

        // Response latency with an empty queue
        lat = 3;
        wait_ack();
        a = imem_addr;
`ifdef FETCH_QUEUE_BYPASS_EN
        check_eq("lat_ack_valid", 16'(valid), 16'(1));
        check_eq("lat_ack_instr", instr, mem_word(a));
        tick();
`else
        check_eq("lat_ack_valid", 16'(valid), 16'(0));
        tick();
        check_eq("lat_next_valid", 16'(valid), 16'(1));
        check_eq("lat_next_instr", instr, mem_word(a));
        check_eq("lat_next_pc1", pc_plus_1, 16'(a + 16'd1));
`endif

        // hlt does not abort an outstanding request
        repeat (6) tick();
        wait_req_any();
        a   = imem_addr;
        hlt = 1'b1;
        repeat (10) tick();
        check_eq("hlt_req", 16'(imem_req), 16'(0));
        check_eq("hlt_valid", 16'(valid), 16'(1));
        check_eq("hlt_pc1", pc_plus_1, 16'(a + 16'd1));
        check_eq("hlt_instr", instr, mem_word(a));
        hlt = 1'b0;
        collect(2, a, 16'(a + 16'd1));

        // Reset mid-request, stale ack afterwards is ignored
        lat = 4;
        wait_req_any();
        hlt = 1'b1;
        do_reset();
        check_eq("mid_rst_req", 16'(imem_req), 16'(0));
        check_eq("mid_rst_valid", 16'(valid), 16'(0));
        stale_cnt++;
        repeat (4) tick();
        check_eq("stale_valid", 16'(valid), 16'(0));
        check_eq("stale_req", 16'(imem_req), 16'(0));
        hlt = 1'b0;
        collect(1, 16'h0000, 16'h0000);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/fetch_queue.md
FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 The block SHALL use parameter DEPTH, default 4, meaning number of queue entries (power of two, 2..16).
REQ-002 The block SHALL have port clk  input  1  rising-edge clock; sole clock.
REQ-003 The block SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 The block SHALL have port imem_req  output  1  instruction-memory request, registered.
REQ-005 The block SHALL have port imem_addr  output  16  request word address, registered.
REQ-006 The block SHALL have port imem_ack  input  1  one-cycle response strobe, variable latency >=1 cycle after req.
REQ-007 The block SHALL have port imem_rdata  input  16  instruction word, valid when imem_ack=1.
REQ-008 The block SHALL have port alt_pc_ctrl  input  1  redirect strobe (jump/taken branch).
REQ-009 The block SHALL have port alt_pc  input  16  redirect target.
REQ-010 The block SHALL have port stall  input  1  consumer (IF/ID register) not accepting.
REQ-011 The block SHALL have port hlt  input  1  halt; freezes consumption and new requests.
REQ-012 The block SHALL have port instr  output  16  head instruction.
REQ-013 The block SHALL have port pc_plus_1  output  16  head entry fetch address + 1.
REQ-014 The block SHALL have port valid  output  1  head entry present.

Function
REQ-015 Each entry SHALL hold {instr, pc_plus_1}; valid=1 iff count>0; instr/pc_plus_1 SHALL be 16'h0000 when valid=0.
REQ-016 Pop SHALL occur when valid & ~stall & ~hlt & ~alt_pc_ctrl.
REQ-017 Fetch FSM states SHALL be IDLE, WAIT, DISCARD.
REQ-018 IDLE->WAIT SHALL occur when ~hlt & ~alt_pc_ctrl & (count after this cycle's pop) < DEPTH; imem_req=1, imem_addr=fpc from next cycle.
REQ-019 In WAIT, imem_req and imem_addr SHALL stay stable until imem_ack; at most one request outstanding.
REQ-020 WAIT with imem_ack & ~alt_pc_ctrl SHALL push {imem_rdata, fpc+1}, set fpc<=fpc+1, deassert imem_req, go IDLE.
REQ-021 alt_pc_ctrl SHALL, in the same edge, empty the queue, set fpc<=alt_pc; from IDLE stay IDLE; from WAIT without ack go DISCARD; from WAIT with ack drop the data, go IDLE.
REQ-022 DISCARD SHALL drop the next imem_ack data and go IDLE; alt_pc_ctrl in DISCARD SHALL update fpc and stay DISCARD.
REQ-023 Simultaneous push and pop SHALL leave count unchanged; push into a full queue SHALL not occur by construction (REQ-018).
REQ-024 fpc and pc_plus_1 SHALL wrap 16'hFFFF->16'h0000.
REQ-025 hlt SHALL not abort an outstanding request; its response SHALL still be pushed.
REQ-026 Minimum latency SHALL be: ack in cycle n -> valid in cycle n+1 (without FETCH_QUEUE_BYPASS_EN).

Reset
REQ-027 rst SHALL set fpc=16'h0000, count=0, state IDLE, imem_req=0, imem_addr=0, valid=0, instr=0, pc_plus_1=0.
REQ-028 rst mid-request SHALL go IDLE; a later stale imem_ack SHALL be ignored (not pushed).

Configuration
REQ-029 With macro FETCH_QUEUE_BYPASS_EN defined, ack with count=0 & ~stall & ~hlt & ~alt_pc_ctrl SHALL drive valid=1, instr=imem_rdata, pc_plus_1=fpc+1 combinationally that cycle and not write the queue.
REQ-030 Without FETCH_QUEUE_BYPASS_EN, all data SHALL pass through the queue (REQ-026).

Verification
REQ-031 Reset then mem latency 1, stall=0: imem_addr 0,1,2,... ; valid pairs instr=mem[k], pc_plus_1=k+1 in order.
REQ-032 stall=1 held, DEPTH=4: exactly 4 entries fill, imem_req stays 0 afterward; release stall -> 4 pops then fetch resumes at addr 4.
REQ-033 alt_pc_ctrl=1, alt_pc=16'h0040 while WAIT for addr 5: queue empties, addr-5 ack dropped, next imem_addr=16'h0040, first valid pc_plus_1=16'h0041.
REQ-034 Redirect coincident with ack: data dropped, state IDLE, next request at alt_pc; no entry pushed.
REQ-035 fpc=16'hFFFF fetch: pushed pc_plus_1=16'h0000, next imem_addr=16'h0000.
REQ-036 With FETCH_QUEUE_BYPASS_EN, empty queue, ack in cycle n: valid=1, instr=imem_rdata in cycle n; without it, valid=1 in cycle n+1.
